// File: rtl/cbl_fetch_pkg.sv
// Shared constants for the CaballoLoco fetch stage and its decode-side consumers.
package cbl_fetch_pkg;

  localparam int unsigned DEF_NUM_INSTR  = 32;
  localparam int unsigned DEF_REG_WIDTH  = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // Bubble word presented to decode whenever no real instruction is available.
  localparam logic [DEF_REG_WIDTH-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/cbl_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface cbl_fetch_if
  import cbl_fetch_pkg::*;
#(
  parameter int unsigned NUM_INSTR = DEF_NUM_INSTR,
  parameter int unsigned REG_WIDTH = DEF_REG_WIDTH
);

  localparam int unsigned PC_W = $clog2(NUM_INSTR);

  logic                 imem_req;
  logic [PC_W-1:0]      imem_addr;
  logic                 imem_ready;
  logic                 imem_valid;
  logic [REG_WIDTH-1:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_valid,
    output imem_data
  );

endinterface

// File: rtl/cbl_fetch_fifo.sv
// Prefetch buffer: circular FIFO with extra-bit pointers to tell full from empty.
module cbl_fetch_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + PW'(1);
      if (pop_i)  rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign count_o = CW'(wr_q - rd_q);
  assign head_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/cbl_fetch.sv
// Fetch stage: PC, credit-based request issue, stale-response dropping after
// redirects, and a prefetch FIFO presenting {instr, pc} to decode.
module cbl_fetch
  import cbl_fetch_pkg::*;
#(
  parameter  int unsigned NUM_INSTR  = DEF_NUM_INSTR,
  parameter  int unsigned REG_WIDTH  = DEF_REG_WIDTH,
  parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  localparam int unsigned PC_W       = $clog2(NUM_INSTR)
) (
  input  logic                 clk,
  input  logic                 rst,
  cbl_fetch_if.master          imem,
  input  logic                 redirect,
  input  logic [PC_W-1:0]      redirect_pc,
  input  logic                 stall,
  output logic                 valid_D,
  output logic [REG_WIDTH-1:0] instr_D,
  output logic [PC_W-1:0]      pc_D
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = REG_WIDTH + PC_W;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic [CNT_W-1:0] occ;
  logic [SUM_W-1:0] inflight;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ENT_W-1:0] head;
  logic             req_c;
  logic             accept;
  logic             push_c;
  logic             pop_c;

  function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
    pc_inc = (pc == PC_W'(NUM_INSTR - 1)) ? '0 : pc + PC_W'(1);
  endfunction

  // Credit check: every accepted request must already own a FIFO slot.
  assign inflight = SUM_W'(occ) + SUM_W'(outst_q);
  assign req_c    = rst && !redirect && (inflight < SUM_W'(FIFO_DEPTH));
  assign accept   = req_c && imem.imem_ready;
  assign push_c   = imem.imem_valid && (drop_q == '0) && !redirect;
  assign pop_c    = !fifo_empty && !stall && !redirect;

  always_comb begin
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q + CNT_W'(accept) - CNT_W'(imem.imem_valid);
    drop_d   = drop_q;
    if (accept) pc_d = pc_inc(pc_q);
    if (imem.imem_valid && (drop_q != '0)) drop_d = drop_q - CNT_W'(1);
    if (push_c) rsp_pc_d = pc_inc(rsp_pc_q);
    // Everything still in flight after a redirect edge belongs to the old path.
    if (redirect) begin
      pc_d     = redirect_pc;
      rsp_pc_d = redirect_pc;
      drop_d   = outst_q - CNT_W'(imem.imem_valid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      rsp_pc_q <= '0;
      outst_q  <= '0;
      drop_q   <= '0;
    end else begin
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      drop_q   <= drop_d;
    end
  end

  cbl_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push_c && (!fifo_full || pop_c)),
    .pop_i   (pop_c),
    .flush_i (redirect),
    .data_i  ({imem.imem_data, rsp_pc_q}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occ),
    .head_o  (head)
  );

  assign imem.imem_req  = req_c;
  assign imem.imem_addr = pc_q;

  assign valid_D = !fifo_empty;
  assign instr_D = valid_D ? head[ENT_W-1:PC_W] : REG_WIDTH'(NOP_INSTR);
  assign pc_D    = valid_D ? head[PC_W-1:0] : '0;

endmodule

// File: tb/tb_cbl_fetch.sv
// Directed bench for cbl_fetch with an in-order instruction memory model (word k = k+100).
module tb_cbl_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [4:0]  redirect_pc;
  logic        stall;
  logic        valid_D;
  logic [31:0] instr_D;
  logic [4:0]  pc_D;

  int n_cmp = 0;
  int n_bad = 0;

  cbl_fetch_if #(.NUM_INSTR(32), .REG_WIDTH(32)) bus ();

  cbl_fetch #(
    .NUM_INSTR  (32),
    .REG_WIDTH  (32),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .valid_D     (valid_D),
    .instr_D     (instr_D),
    .pc_D        (pc_D)
  );

  always #5 clk = ~clk;

  // Memory model: accepted requests queue up and answer in order after lat cycles.
  typedef struct {
    logic [4:0]  addr;
    int unsigned rdy;
  } rsp_t;

  rsp_t        q[$];
  rsp_t        r;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  bit          rand_mode = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      bus.imem_valid = 1'b0;
      bus.imem_data  = '0;
      bus.imem_ready = 1'b1;
    end else begin
      if (bus.imem_valid) void'(q.pop_front());
      if (bus.imem_req && bus.imem_ready) begin
        r.addr = bus.imem_addr;
        r.rdy  = cyc + (rand_mode ? $urandom_range(1, 3) : lat);
        q.push_back(r);
      end
      cyc++;
      #1;
      bus.imem_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (q.size() > 0 && q[0].rdy <= cyc) begin
        bus.imem_valid = 1'b1;
        bus.imem_data  = 32'(q[0].addr) + 32'd100;
      end else begin
        bus.imem_valid = 1'b0;
        bus.imem_data  = '0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic expect_pc(input string tag, input logic [4:0] p);
    int w = 0;
    while (!valid_D && w < 10) begin
      step();
      w++;
    end
    chk({tag, "_valid"}, 32'(valid_D), 32'd1);
    chk({tag, "_pc"}, 32'(pc_D), 32'(p));
    chk({tag, "_instr"}, instr_D, 32'(p) + 32'd100);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_req"}, 32'(bus.imem_req), 32'd0);
    chk({tag, "_addr"}, 32'(bus.imem_addr), 32'd0);
    chk({tag, "_valid"}, 32'(valid_D), 32'd0);
    chk({tag, "_instr"}, instr_D, 32'd0);
    chk({tag, "_pc"}, 32'(pc_D), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] exp_pc;
    int         pops;

    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("reset");

    // Free run, 1-cycle memory
    rst = 1'b1;
    #1 chk("release_req", 32'(bus.imem_req), 32'd1);
    step();
    chk("first_edge_valid", 32'(valid_D), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("run_valid", 32'(valid_D), 32'd1);
      chk("run_pc", 32'(pc_D), 32'(i));
      chk("run_instr", instr_D, 32'(i) + 32'd100);
    end

    // Stall held 8 cycles with pc 3 at the head
    stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("stall_pc", 32'(pc_D), 32'd3);
      chk("stall_instr", instr_D, 32'd103);
    end
    chk("stall_req_low", 32'(bus.imem_req), 32'd0);
    chk("stall_addr", 32'(bus.imem_addr), 32'd7);
    stall = 1'b0;
    for (int i = 4; i < 9; i++) begin
      step();
      chk("resume_valid", 32'(valid_D), 32'd1);
      chk("resume_pc", 32'(pc_D), 32'(i));
      chk("resume_instr", instr_D, 32'(i) + 32'd100);
    end

    // Redirect to 9 with two 2-cycle requests outstanding
    rst = 1'b0;
    lat = 2;
    step();
    rst = 1'b1;
    step(2);
    chk("pre_redir_req", 32'(bus.imem_req), 32'd1);
    redirect = 1'b1;
    redirect_pc = 5'd9;
    #1 chk("redir_req_low", 32'(bus.imem_req), 32'd0);
    step();
    redirect = 1'b0;
    #1;
    chk("redir_valid0", 32'(valid_D), 32'd0);
    chk("redir_addr", 32'(bus.imem_addr), 32'd9);
    chk("redir_req", 32'(bus.imem_req), 32'd1);
    step();
    chk("redir_valid1", 32'(valid_D), 32'd0);
    step();
    chk("redir_valid2", 32'(valid_D), 32'd0);
    step();
    chk("redir_tgt_valid", 32'(valid_D), 32'd1);
    chk("redir_tgt_pc", 32'(pc_D), 32'd9);
    chk("redir_tgt_instr", instr_D, 32'd109);
    step();
    chk("redir_next_pc", 32'(pc_D), 32'd10);
    chk("redir_next_instr", instr_D, 32'd110);

    // PC wrap 30, 31, 0, 1
    lat = 1;
    step(4);
    redirect = 1'b1;
    redirect_pc = 5'd30;
    step();
    redirect = 1'b0;
    chk("wrap_flush_valid", 32'(valid_D), 32'd0);
    expect_pc("wrap30", 5'd30);
    step();
    expect_pc("wrap31", 5'd31);
    step();
    expect_pc("wrap0", 5'd0);
    step();
    expect_pc("wrap1", 5'd1);
    step();

    // Random ready, latency 1..3, random stall
    rand_mode = 1'b1;
    exp_pc = 5'd2;
    pops = 0;
    for (int i = 0; i < 200; i++) begin
      if (valid_D) begin
        chk("rand_pc", 32'(pc_D), 32'(exp_pc));
        chk("rand_instr", instr_D, 32'(exp_pc) + 32'd100);
      end
      chk("rand_inflight_le4", 32'(q.size() <= 4), 32'd1);
      stall = ($urandom_range(0, 3) == 0);
      if (valid_D && !stall) begin
        exp_pc = exp_pc + 5'd1;
        pops++;
      end
      step();
    end
    chk("rand_progress", 32'(pops >= 30), 32'd1);
    rand_mode = 1'b0;
    stall = 1'b0;
    step(3);

    // Asynchronous reset between edges
    #2 rst = 1'b0;
    #1 chk_zero_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("restart_addr", 32'(bus.imem_addr), 32'd0);
    chk("restart_req", 32'(bus.imem_req), 32'd1);
    step();
    chk("restart_valid0", 32'(valid_D), 32'd0);
    step();
    chk("restart_pc0", 32'(pc_D), 32'd0);
    chk("restart_instr0", instr_D, 32'd100);
    step();
    chk("restart_pc1", 32'(pc_D), 32'd1);
    chk("restart_instr1", instr_D, 32'd101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
